// File: rtl/order_feed_gen.sv
`default_nettype none
// ============================================================================
// Module   : order_feed_gen
// Purpose  : Buy/sell quote generator driven by two tap-programmable LFSRs,
//            tick paced, with valid/ready delivery, sequence and drop counts.
//            Optional macro SPREAD_GUARD_EN enforces sell >= buy + MIN_SPREAD.
// Revision : 1.0 - initial release
// ============================================================================
module order_feed_gen #(
  parameter int unsigned          PRICE_W    = 8,
  parameter int unsigned          LFSR_W     = 16,
  parameter int unsigned          RAND_BITS  = 5,
  parameter int unsigned          TICK_DIV   = 2097152,
  parameter int unsigned          BUY_BASE   = 50,
  parameter int unsigned          SELL_BASE  = 55,
  parameter logic [LFSR_W-1:0]    BUY_TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0]    SELL_TAPS  = 16'hD008,
  parameter logic [LFSR_W-1:0]    BUY_SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0]    SELL_SEED  = 16'h3C21,
  parameter int unsigned          SEQ_W      = 8,
  parameter int unsigned          DROP_W     = 8,
  parameter int unsigned          MIN_SPREAD = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_buy,
  input  logic [LFSR_W-1:0]  seed_sell,
  input  logic               order_ready,
  output logic               order_valid,
  output logic [PRICE_W-1:0] buy_price,
  output logic [PRICE_W-1:0] sell_price,
  output logic [SEQ_W-1:0]   order_seq,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int unsigned       CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned       PW1       = PRICE_W + 1;
  localparam int unsigned       PW2       = PRICE_W + 2;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PW1-1:0]    PRICE_MAX = {1'b0, {PRICE_W{1'b1}}};
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};
`ifdef SPREAD_GUARD_EN
  localparam bit                GUARD_ON  = 1'b1;
`else
  localparam bit                GUARD_ON  = 1'b0;
`endif

  logic [LFSR_W-1:0]  lfsr_buy_q,  lfsr_buy_d;
  logic [LFSR_W-1:0]  lfsr_sell_q, lfsr_sell_d;
  logic [CNT_W-1:0]   tick_cnt_q,  tick_cnt_d;
  logic               order_valid_q, order_valid_d;
  logic [PRICE_W-1:0] buy_price_q,  buy_price_d;
  logic [PRICE_W-1:0] sell_price_q, sell_price_d;
  logic [SEQ_W-1:0]   order_seq_q,  order_seq_d;
  logic [DROP_W-1:0]  drop_cnt_q,   drop_cnt_d;

  logic               tick;
  logic               xfer;
  logic [LFSR_W-1:0]  nxt_buy, nxt_sell;
  logic [PW1-1:0]     buy_sum, sell_sum, buy_sat, sell_sat;
  logic [PW2-1:0]     spread_floor;
  logic [PW1-1:0]     sell_guard;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] taps);
    return {s[LFSR_W-2:0], ^(s & taps)};
  endfunction

  always_comb begin
    tick     = enable && (tick_cnt_q == TICK_LAST);
    xfer     = order_valid_q && order_ready;
    nxt_buy  = lfsr_step(lfsr_buy_q,  BUY_TAPS);
    nxt_sell = lfsr_step(lfsr_sell_q, SELL_TAPS);

    // One spare bit catches the carry so the ceiling clamp is exact.
    buy_sum  = PW1'(BUY_BASE)  + PW1'(nxt_buy[RAND_BITS-1:0]);
    sell_sum = PW1'(SELL_BASE) + PW1'(nxt_sell[RAND_BITS-1:0]);
    buy_sat  = (buy_sum  > PRICE_MAX) ? PRICE_MAX : buy_sum;
    sell_sat = (sell_sum > PRICE_MAX) ? PRICE_MAX : sell_sum;

    spread_floor = PW2'(buy_sat) + PW2'(MIN_SPREAD);
    sell_guard   = sell_sat;
    if (GUARD_ON && (PW2'(sell_sat) < spread_floor))
      sell_guard = (spread_floor > PW2'(PRICE_MAX)) ? PRICE_MAX : spread_floor[PW1-1:0];
  end

  always_comb begin
    lfsr_buy_d    = lfsr_buy_q;
    lfsr_sell_d   = lfsr_sell_q;
    order_valid_d = order_valid_q;
    buy_price_d   = buy_price_q;
    sell_price_d  = sell_price_q;
    order_seq_d   = order_seq_q;
    drop_cnt_d    = drop_cnt_q;
    tick_cnt_d    = (enable && !tick) ? tick_cnt_q + 1'b1 : '0;

    if (seed_load) begin
      // Zero seeds fall back to defaults so the LFSR can never lock up.
      lfsr_buy_d  = (seed_buy  == '0) ? BUY_SEED  : seed_buy;
      lfsr_sell_d = (seed_sell == '0) ? SELL_SEED : seed_sell;
      tick_cnt_d  = '0;
      if (xfer)
        order_valid_d = 1'b0;
    end else if (tick) begin
      lfsr_buy_d    = nxt_buy;
      lfsr_sell_d   = nxt_sell;
      buy_price_d   = buy_sat[PRICE_W-1:0];
      sell_price_d  = sell_guard[PRICE_W-1:0];
      order_valid_d = 1'b1;
      order_seq_d   = order_seq_q + 1'b1;
      if (order_valid_q && !order_ready && (drop_cnt_q != DROP_MAX))
        drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (xfer) begin
      order_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_buy_q    <= BUY_SEED;
      lfsr_sell_q   <= SELL_SEED;
      tick_cnt_q    <= '0;
      order_valid_q <= 1'b0;
      buy_price_q   <= '0;
      sell_price_q  <= '0;
      order_seq_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      lfsr_buy_q    <= lfsr_buy_d;
      lfsr_sell_q   <= lfsr_sell_d;
      tick_cnt_q    <= tick_cnt_d;
      order_valid_q <= order_valid_d;
      buy_price_q   <= buy_price_d;
      sell_price_q  <= sell_price_d;
      order_seq_q   <= order_seq_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign order_valid = order_valid_q;
  assign buy_price   = buy_price_q;
  assign sell_price  = sell_price_q;
  assign order_seq   = order_seq_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_order_feed_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_feed_gen
// Purpose  : Directed self-checking bench for order_feed_gen (TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_order_feed_gen;

  logic        clk = 1'b0;
  logic        reset, enable, seed_load, order_ready;
  logic [15:0] seed_buy, seed_sell;
  logic        order_valid;
  logic [7:0]  buy_price, sell_price, order_seq, drop_cnt;

  logic        seed_load2, order_ready2;
  logic [15:0] seed_buy2, seed_sell2;
  logic        order_valid2;
  logic [7:0]  buy_price2, sell_price2, order_seq2;
  logic [1:0]  drop_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] mb, ms;

  always #5 clk = ~clk;

  order_feed_gen #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed_buy(seed_buy), .seed_sell(seed_sell), .order_ready(order_ready),
    .order_valid(order_valid), .buy_price(buy_price), .sell_price(sell_price),
    .order_seq(order_seq), .drop_cnt(drop_cnt)
  );

  order_feed_gen #(.TICK_DIV(4), .DROP_W(2), .BUY_BASE(250)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load2),
    .seed_buy(seed_buy2), .seed_sell(seed_sell2), .order_ready(order_ready2),
    .order_valid(order_valid2), .buy_price(buy_price2), .sell_price(sell_price2),
    .order_seq(order_seq2), .drop_cnt(drop_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference Fibonacci step written bit by bit.
  function automatic logic [15:0] ref_next(input logic [15:0] s, input logic [15:0] taps);
    logic fb = 1'b0;
    for (int i = 0; i < 16; i++)
      if (taps[i]) fb = fb ^ s[i];
    return {s[14:0], fb};
  endfunction

  function automatic logic [31:0] ref_price(input int base, input logic [15:0] l);
    int s = base + int'(l[4:0]);
    return (s > 255) ? 32'd255 : 32'(s);
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; seed_load = 1'b0; order_ready = 1'b1;
    seed_buy = '0; seed_sell = '0;
    seed_load2 = 1'b0; order_ready2 = 1'b0; seed_buy2 = '0; seed_sell2 = '0;
    repeat (3) step();
    chk("rst_valid", 32'(order_valid), 0);
    chk("rst_buy",   32'(buy_price), 0);
    chk("rst_sell",  32'(sell_price), 0);
    chk("rst_seq",   32'(order_seq), 0);
    chk("rst_drop",  32'(drop_cnt), 0);
    chk("rst_lfsr_b", 32'(dut.lfsr_buy_q), 32'hACE1);

    // First quote appears in the fifth cycle after release.
    reset = 1'b0;
    repeat (3) step();
    chk("t1_not_yet", 32'(order_valid), 0);
    step();
    chk("t1_valid", 32'(order_valid), 1);
    chk("t1_buy",   32'(buy_price), 53);
    chk("t1_sell",  32'(sell_price), 58);
    chk("t1_seq",   32'(order_seq), 1);
    chk("t1_lfsr_b", 32'(dut.lfsr_buy_q), 32'h59C3);
    chk("t1_lfsr_s", 32'(dut.lfsr_sell_q), 32'h7843);
    mb = 16'h59C3; ms = 16'h7843;
    step();
    chk("t1_xfer_clr", 32'(order_valid), 0);

    // Back-pressure across three ticks.
    order_ready = 1'b0;
    repeat (3) step();
    mb = ref_next(mb, 16'hB400); ms = ref_next(ms, 16'hD008);
    chk("t2_valid", 32'(order_valid), 1);
    chk("t2_seq",   32'(order_seq), 2);
    for (int t = 1; t <= 2; t++) begin
      repeat (3) step();
      chk("t2_stable_buy",  32'(buy_price),  ref_price(50, mb));
      chk("t2_stable_sell", 32'(sell_price), ref_price(55, ms));
      step();
      mb = ref_next(mb, 16'hB400); ms = ref_next(ms, 16'hD008);
      chk("t2_seq_tick",  32'(order_seq), 32'(2 + t));
      chk("t2_drop_tick", 32'(drop_cnt),  32'(t));
      chk("t2_buy_tick",  32'(buy_price), ref_price(50, mb));
    end

    // Ready on the tick cycle: replace without drop.
    repeat (3) step();
    chk("t3_valid_pre", 32'(order_valid), 1);
    order_ready = 1'b1;
    step();
    mb = ref_next(mb, 16'hB400); ms = ref_next(ms, 16'hD008);
    order_ready = 1'b0;
    chk("t3_valid", 32'(order_valid), 1);
    chk("t3_seq",   32'(order_seq), 5);
    chk("t3_drop",  32'(drop_cnt), 2);
    chk("t3_sell",  32'(sell_price), ref_price(55, ms));

    // Seed load on the tick cycle.
    repeat (3) step();
    seed_load = 1'b1; seed_buy = 16'h0000; seed_sell = 16'h0001;
    step();
    seed_load = 1'b0;
    chk("t4_seq",    32'(order_seq), 5);
    chk("t4_valid",  32'(order_valid), 1);
    chk("t4_lfsr_b", 32'(dut.lfsr_buy_q), 32'hACE1);
    chk("t4_lfsr_s", 32'(dut.lfsr_sell_q), 32'h0001);
    chk("t4_cnt",    32'(dut.tick_cnt_q), 0);
    repeat (3) step();
    chk("t4_no_quote_yet", 32'(order_seq), 5);
    step();
    chk("t4_seq_next", 32'(order_seq), 6);
    chk("t4_buy",      32'(buy_price), 53);
    chk("t4_sell",     32'(sell_price), 57);
    chk("t4_drop",     32'(drop_cnt), 3);

    // Enable low holds the counter and produces no quotes.
    order_ready = 1'b1; enable = 1'b0;
    step();
    repeat (5) step();
    chk("en_valid", 32'(order_valid), 0);
    chk("en_seq",   32'(order_seq), 6);
    chk("en_cnt",   32'(dut.tick_cnt_q), 0);
    enable = 1'b1; order_ready = 1'b0;

    // Asynchronous reset while an order is pending.
    repeat (4) step();
    chk("t5_valid_pre", 32'(order_valid), 1);
    chk("t5_seq_pre",   32'(order_seq), 7);
    step();
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", 32'(order_valid), 0);
    chk("t5_seq",   32'(order_seq), 0);
    chk("t5_drop",  32'(drop_cnt), 0);
    chk("t5_cnt",   32'(dut.tick_cnt_q), 0);
    chk("t5_buy",   32'(buy_price), 0);
    step();

    // Saturation and small drop counter on the second instance.
    reset = 1'b0;
    seed_load2 = 1'b1; seed_buy2 = 16'h040F; seed_sell2 = 16'h0001;
    step();
    seed_load2 = 1'b0;
    repeat (4) step();
    chk("sat_valid", 32'(order_valid2), 1);
    chk("sat_buy",   32'(buy_price2), 255);
`ifdef SPREAD_GUARD_EN
    chk("sat_sell",  32'(sell_price2), 255);
`else
    chk("sat_sell",  32'(sell_price2), 57);
`endif
    chk("sat_seq",   32'(order_seq2), 1);
    repeat (12) step();
    chk("dsat_drop3", 32'(drop_cnt2), 3);
    repeat (8) step();
    chk("dsat_drop5", 32'(drop_cnt2), 3);
    chk("dsat_seq",   32'(order_seq2), 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/order_feed_gen.md
Name: order_feed_gen

Overview:
Parametrised successor of the LFSR price feed. It produces a stream of buy/sell order quotes from two independent tap-programmable LFSRs. Quotes are paced by a single-clock-domain tick enable; the block uses no derived clock. Each quote is delivered over a valid/ready handshake with a sequence number, drop accounting and runtime seed reload. It sits between the stimulus source and the matching engine.

Parameters:
PRICE_W, 8, width of buy/sell price outputs
LFSR_W, 16, width of each LFSR
RAND_BITS, 5, low LFSR bits added to base price (RAND_BITS <= LFSR_W, RAND_BITS <= PRICE_W)
TICK_DIV, 2097152, clk cycles per quote tick (>= 1)
BUY_BASE, 50, buy price offset
SELL_BASE, 55, sell price offset
BUY_TAPS, 16'hB400, feedback mask for buy LFSR (bits 15,13,12,10)
SELL_TAPS, 16'hD008, feedback mask for sell LFSR (bits 15,14,12,3)
BUY_SEED, 16'hACE1, buy LFSR reset/default seed
SELL_SEED, 16'h3C21, sell LFSR reset/default seed
SEQ_W, 8, order sequence counter width
DROP_W, 8, drop counter width
MIN_SPREAD, 1, minimum sell-buy spread (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run tick counter; low = hold tick counter at 0
seed_load  in  1  one-cycle strobe: load seed_buy/seed_sell
seed_buy  in  LFSR_W  runtime seed for buy LFSR
seed_sell  in  LFSR_W  runtime seed for sell LFSR
order_ready  in  1  consumer accepts current order
order_valid  out  1  order fields valid
buy_price  out  PRICE_W  quoted buy price
sell_price  out  PRICE_W  quoted sell price
order_seq  out  SEQ_W  sequence number of current order
drop_cnt  out  DROP_W  count of overwritten unaccepted orders

Behaviour:
- Reset (async, active-high) sets: lfsr_buy=BUY_SEED, lfsr_sell=SELL_SEED, tick_cnt=0, order_valid=0, buy_price=0, sell_price=0, order_seq=0, drop_cnt=0.
- Reset mid-operation discards any pending order immediately. No handshake completes on the reset edge.
- Tick counter: when enable=1, it counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where tick_cnt==TICK_DIV-1 and enable=1. When enable=0, tick_cnt is cleared to 0 and no tick occurs. A pending order stays until it is accepted.
- LFSR step: Fibonacci, shift toward MSB. New bit[0] = XOR reduction of (lfsr & TAPS). Both LFSRs step only on tick.
- Tick edge actions, all registered on the same edge:
  - both LFSRs advance;
  - buy_price = BUY_BASE + next_lfsr_buy[RAND_BITS-1:0];
  - sell_price = SELL_BASE + next_lfsr_sell[RAND_BITS-1:0];
  - order_valid <= 1;
  - order_seq <= order_seq + 1, wrapping.
- Latency: the new quote is visible in the cycle after the tick cycle.
- Price arithmetic: computed at PRICE_W+1 bits, then saturated to 2^PRICE_W-1.
- Handshake: a transfer occurs when order_valid && order_ready on a rising edge. Fields are stable while valid && !ready. After a transfer with no tick in the same cycle, order_valid <= 0 on the next edge.
- Tick and transfer in the same cycle: the new order loads, order_valid stays 1, no drop is counted.
- Tick while valid && !ready: the order is overwritten with the new quote and drop_cnt increments. drop_cnt saturates at 2^DROP_W-1.
- seed_load has priority over tick:
  - LFSRs load seed_buy/seed_sell; a zero seed is replaced by the parameter default, so the all-zero lockup state is impossible;
  - tick_cnt clears to 0;
  - the pending order and its valid are unaffected; no quote is generated that cycle.
- The drop counter and sequence counter are never cleared except by reset.

Optional Feature:
Macro SPREAD_GUARD_EN.
- Defined: after saturation, if sell_price < buy_price + MIN_SPREAD, then sell_price = min(buy_price + MIN_SPREAD, 2^PRICE_W-1). This guarantees a non-crossed book except at the saturation ceiling.
- Undefined: sell_price is emitted unmodified, and crossed quotes are possible.

Test Plan:
- Reset, TICK_DIV=4, enable=1, order_ready=1 -> first order_valid in the 5th cycle after reset release; buy_price=53 (lfsr 0x59C3), sell_price=58 (lfsr 0x7843), order_seq=1.
- order_ready=0 held across 3 ticks, TICK_DIV=4 -> drop_cnt=2, order_seq=3, order_valid stays 1, fields stable between ticks; DROP_W=2 with 5 drops -> drop_cnt saturates at 3.
- Ready asserted exactly on the tick cycle -> no drop, order_valid continuous, next order_seq increments by 1.
- seed_load with seed_buy=0, seed_sell=0x0001 in the tick cycle -> no new order that cycle, lfsr_buy=0xACE1, lfsr_sell=0x0001, tick_cnt=0; next quote arrives TICK_DIV cycles later.
- BUY_BASE=250, RAND_BITS=5, PRICE_W=8 with LFSR low bits 0x1F -> buy_price=255 (saturated); with SPREAD_GUARD_EN, sell_price=255.
- Async reset asserted mid-count while order_valid=1 -> order_valid=0 and all counters 0 immediately, without waiting for a clk edge.
